multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the MIPS-subset datapath. It fetches one instruction at a time from instruction memory over a valid handshake and decodes the R-type and I-type ALU classes. It then steps the datapath through FETCH, DECODE, EXECUTE and WRITEBACK, producing the ALU, shifter, register-file and PC strobes. It replaces purely combinational control when shifts are executed iteratively over several cycles.

---
 rtl/multicycle_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer
module multicycle_sequencer #(
    parameter int SHIFT_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 imem_valid,
    input  logic [31:0]          imem_rdata,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 instruction_class,
    output logic [3:0]           alu_control,
    output logic                 shift,
    output logic                 alu_en,
    output logic                 reg_write,
    output logic                 illegal,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam int XW = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
    localparam logic [XW-1:0]        XCNT_SHIFT = XW'(SHIFT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       is_halt;
        logic       is_illegal;
        logic       cls;
        logic [3:0] alu;
        logic       sh;
    } dec_t;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            ir;
    logic [XW-1:0]          exec_cnt;
    dec_t                   rdata_dec;
    dec_t                   ir_dec;
    logic                   ir_unused;

    function automatic dec_t decode(input logic [31:0] word);
        dec_t d;
        d = '0;
        if (word[31:26] == OP_RTYPE) begin
            case (word[5:0])
                6'b100000: d.alu = 4'b0010;
                6'b100010: d.alu = 4'b0100;
                6'b100100: d.alu = 4'b0000;
                6'b100101: d.alu = 4'b0001;
                6'b000000: begin
                    d.alu = 4'b1000;
                    d.sh  = 1'b1;
                end
                6'b000010: begin
                    d.alu = 4'b1001;
                    d.sh  = 1'b1;
                end
                default:   d.is_illegal = 1'b1;
            endcase
        end else if (word[31:26] == OP_HALT) begin
            d.is_halt = 1'b1;
        end else begin
            d.cls = 1'b1;
            d.alu = 4'b0010;
        end
        return d;
    endfunction

    assign rdata_dec = decode(imem_rdata);
    assign ir_dec    = decode(ir);

    // Only opcode and funct steer control; the operand fields belong to the datapath.
    assign ir_unused = ^ir[25:6];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (ir_dec.is_halt)         state_next = S_HALT;
                else if (ir_dec.is_illegal) state_next = S_FETCH;
                else                        state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (exec_cnt == '0) state_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                if (start) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        alu_en    = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_valid;
                busy     = 1'b1;
            end
            S_DECODE: begin
                busy    = 1'b1;
                illegal = ir_dec.is_illegal;
                pc_inc  = ir_dec.is_illegal | ir_dec.is_halt;
            end
            S_EXECUTE: begin
                busy   = 1'b1;
                alu_en = 1'b1;
            end
            S_WRITEBACK: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                pc_inc    = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Decode results are captured with the IR so they are already valid during DECODE;
    // halt and illegal words leave the previous ALU setup in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir                <= '0;
            instruction_class <= 1'b0;
            alu_control       <= 4'b0000;
            shift             <= 1'b0;
        end else if (ir_load) begin
            ir <= imem_rdata;
            if (!rdata_dec.is_halt && !rdata_dec.is_illegal) begin
                instruction_class <= rdata_dec.cls;
                alu_control       <= rdata_dec.alu;
                shift             <= rdata_dec.sh;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_cnt <= '0;
        end else if (state == S_DECODE) begin
            exec_cnt <= ir_dec.sh ? XCNT_SHIFT : '0;
        end else if (state == S_EXECUTE && exec_cnt != '0) begin
            exec_cnt <= exec_cnt - XW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
        end else if (state == S_WRITEBACK && instr_count != CNT_MAX) begin
            instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic        ir_load;
    logic        pc_inc;
    logic        instruction_class;
    logic [3:0]  alu_control;
    logic        shift;
    logic        alu_en;
    logic        reg_write;
    logic        illegal;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_sequencer #(.SHIFT_CYCLES(4), .CNT_WIDTH(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .imem_valid        (imem_valid),
        .imem_rdata        (imem_rdata),
        .imem_req          (imem_req),
        .ir_load           (ir_load),
        .pc_inc            (pc_inc),
        .instruction_class (instruction_class),
        .alu_control       (alu_control),
        .shift             (shift),
        .alu_en            (alu_en),
        .reg_write         (reg_write),
        .illegal           (illegal),
        .busy              (busy),
        .halted            (halted),
        .instr_count       (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          stall;
        bit          pulse;
        int          cyc;
        int          ae;
        int          rw;
        int          ill;
        int          pci;
        logic [3:0]  alu;
        logic        sh;
        logic        cl;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered mid-cycle in FETCH with imem_valid low; returns mid-cycle once back in FETCH or HALT.
    task automatic run_instr(input logic [31:0] word, input int stall, input bit pulse,
                             output int cyc, output int ae, output int rw,
                             output int ill, output int pci);
        bit done;
        cyc = 0; ae = 0; rw = 0; ill = 0; pci = 0;
        done = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("stall_req", imem_req, 1);
            check("stall_load", ir_load, 0);
            step();
            start = pulse;
            #1;
            cyc++;
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        #1;
        check("load", ir_load, 1);
        cyc++;
        for (int i = 0; i < 20; i++) begin
            step();
            imem_valid = 1'b0;
            start      = pulse;
            #1;
            if (imem_req || halted) begin
                start = 1'b0;
                done  = 1'b1;
                break;
            end
            ae  += int'(alu_en);
            rw  += int'(reg_write);
            ill += int'(illegal);
            pci += int'(pc_inc);
            cyc++;
        end
        start = 1'b0;
        check("complete", done, 1);
    endtask

    initial begin
        int cyc, ae, rw, ill, pci;
        int exp_cnt;

        vecs[0] = '{32'h00021080, 0, 1'b0, 7, 4, 1, 0, 1, 4'b1000, 1'b1, 1'b0};
        vecs[1] = '{32'h00021082, 3, 1'b1, 10, 4, 1, 0, 1, 4'b1001, 1'b1, 1'b0};
        vecs[2] = '{32'h0022182A, 0, 1'b0, 2, 0, 0, 1, 1, 4'b1001, 1'b1, 1'b0};
        vecs[3] = '{32'h00221822, 1, 1'b1, 5, 1, 1, 0, 1, 4'b0100, 1'b0, 1'b0};
        vecs[4] = '{32'h00221824, 0, 1'b0, 4, 1, 1, 0, 1, 4'b0000, 1'b0, 1'b0};
        vecs[5] = '{32'h00221825, 0, 1'b0, 4, 1, 1, 0, 1, 4'b0001, 1'b0, 1'b0};
        vecs[6] = '{32'h20220005, 2, 1'b0, 6, 1, 1, 0, 1, 4'b0010, 1'b0, 1'b1};

        reset_n    = 1'b1;
        start      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;

        #3 reset_n = 1'b0;
        #1;
        check("rst_ctrl", {imem_req, ir_load, pc_inc, instruction_class, shift,
                           alu_en, reg_write, illegal, busy, halted}, 0);
        check("rst_alu", alu_control, 0);
        check("rst_cnt", instr_count, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        #1;
        check("idle_busy", busy, 0);
        check("idle_req", imem_req, 0);

        // add, cycle by cycle
        start = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h00221820;
        step();
        start = 1'b0;
        #1;
        check("add_c1_req", imem_req, 1);
        check("add_c1_load", ir_load, 1);
        step();
        imem_valid = 1'b0;
        #1;
        check("add_c2_alu", alu_control, 4'b0010);
        check("add_c2_class", instruction_class, 0);
        check("add_c2_shift", shift, 0);
        check("add_c2_alu_en", alu_en, 0);
        step(); #1;
        check("add_c3_alu_en", alu_en, 1);
        check("add_c3_rw", reg_write, 0);
        step(); #1;
        check("add_c4_rw", reg_write, 1);
        check("add_c4_pc", pc_inc, 1);
        check("add_c4_alu_en", alu_en, 0);
        step(); #1;
        check("add_cnt", instr_count, 1);
        check("add_refetch", imem_req, 1);
        check("add_rw_done", reg_write, 0);
        exp_cnt = 1;

        foreach (vecs[k]) begin
            run_instr(vecs[k].word, vecs[k].stall, vecs[k].pulse, cyc, ae, rw, ill, pci);
            exp_cnt += vecs[k].rw;
            check($sformatf("v%0d_cycles", k), cyc, vecs[k].cyc);
            check($sformatf("v%0d_alu_en", k), ae, vecs[k].ae);
            check($sformatf("v%0d_rw", k), rw, vecs[k].rw);
            check($sformatf("v%0d_illegal", k), ill, vecs[k].ill);
            check($sformatf("v%0d_pc_inc", k), pci, vecs[k].pci);
            check($sformatf("v%0d_alu", k), alu_control, vecs[k].alu);
            check($sformatf("v%0d_shift", k), shift, vecs[k].sh);
            check($sformatf("v%0d_class", k), instruction_class, vecs[k].cl);
            check($sformatf("v%0d_cnt", k), instr_count, exp_cnt);
            check($sformatf("v%0d_fetch", k), imem_req, 1);
        end

        // halt
        run_instr(32'hFC000000, 0, 1'b0, cyc, ae, rw, ill, pci);
        check("halt_cycles", cyc, 2);
        check("halt_pc_inc", pci, 1);
        check("halt_rw", rw, 0);
        check("halt_alu_en", ae, 0);
        check("halt_flag", halted, 1);
        check("halt_busy", busy, 0);
        repeat (3) step();
        #1;
        check("halt_hold", halted, 1);
        check("halt_cnt", instr_count, exp_cnt);
        step();
        start = 1'b1;
        #1;
        check("halt_pre_start", halted, 1);
        step();
        start = 1'b0;
        #1;
        check("resume_req", imem_req, 1);
        check("resume_halted", halted, 0);
        run_instr(32'h00221820, 0, 1'b0, cyc, ae, rw, ill, pci);
        exp_cnt++;
        check("resume_cycles", cyc, 4);
        check("resume_rw", rw, 1);
        check("resume_cnt", instr_count, exp_cnt);

        // reset in EXECUTE
        imem_valid = 1'b1;
        imem_rdata = 32'h00021080;
        step();
        imem_valid = 1'b0;
        step();
        #1;
        check("mid_alu_en", alu_en, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {imem_req, ir_load, pc_inc, instruction_class, shift,
                               alu_en, reg_write, illegal, busy, halted}, 0);
        check("mid_rst_alu", alu_control, 0);
        check("mid_rst_cnt", instr_count, 0);
        step();
        reset_n = 1'b1;
        step();
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_req", imem_req, 0);
        check("post_rst_rw", reg_write, 0);
        check("post_rst_cnt", instr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
